// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
// Holds the controller state encoding and the default word length.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WORD_END = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// RESET_VAL matches the pin's idle level so reset does not fabricate an edge.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= STAGES'({chain, d});
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 slave, MSB first, with synchronized pins and back-to-back words per frame.
// Optional overrun flag: define SPI_SLAVE_OVERRUN_EN to add the rx_overrun output.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic              rx_overrun
`endif
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_t        state, next_state;
  logic              sclk_s, cs_n_s, mosi_s, sclk_d, cs_n_d;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise, last_bit, commit;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, shadow, load_word;
  logic              reload;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk_i), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n_i), .q(cs_n_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi_i), .q(mosi_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d <= 1'b0;
      cs_n_d <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;
  assign last_bit  = (state == SHIFT) && sclk_rise && (bit_cnt == LAST_BIT);
  // A chip-select release wins over a pending word commit.
  assign commit    = (state == WORD_END) && !cs_rise;
  assign load_word = tx_load ? tx_data : shadow;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (cs_fall) next_state = SHIFT;
      SHIFT: begin
        if (cs_rise)       next_state = IDLE;
        else if (last_bit) next_state = WORD_END;
      end
      WORD_END: next_state = cs_rise ? IDLE : SHIFT;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      shadow  <= '0;
      reload  <= 1'b0;
    end else begin
      if (tx_load) shadow <= tx_data;
      if (state == IDLE) begin
        if (cs_fall) begin
          bit_cnt <= '0;
          tx_sr   <= load_word;
          rx_sr   <= '0;
          reload  <= 1'b0;
        end
      end else if (cs_rise) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        reload  <= 1'b0;
      end else if (state == SHIFT) begin
        if (sclk_rise) begin
          rx_sr   <= {rx_sr[DATA_W-2:0], mosi_s};
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        end
        // The first falling edge after a finished word presents the next word's MSB.
        if (sclk_fall) begin
          if (reload) begin
            tx_sr  <= load_word;
            reload <= 1'b0;
          end else begin
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
      end else begin
        bit_cnt <= '0;
        reload  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (commit) begin
      rx_data  <= rx_sr;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst)                              rx_overrun <= 1'b0;
    else if (commit && rx_valid && !rx_ack) rx_overrun <= 1'b1;
    else if (rx_ack)                      rx_overrun <= 1'b0;
  end
`endif

  assign miso_o = ~cs_n_s & tx_sr[DATA_W-1];
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: acts as SPI mode 0 master with a scoreboard.
// Overrun checks are compiled in when SPI_SLAVE_OVERRUN_EN is defined.
module tb_spi_slave;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst, sclk_i, cs_n_i, mosi_i, miso_o;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_load, rx_valid, rx_ack, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic         rx_overrun;
`endif

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] tx_exp_q[$];
  logic [W-1:0] shadow_model;

  spi_slave #(.DATA_W(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_overrun(rx_overrun)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] w);
    @(negedge clk);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    shadow_model = w;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    cycles(1);
    rx_ack = 1'b0;
    cycles(1);
  endtask

  // Master side of one word; full words queue their expected rx and miso values.
  task automatic shift_word(input logic [W-1:0] w, input int nbits, input bit ack_last,
                            output logic [W-1:0] miso_word);
    miso_word = '0;
    if (nbits == W) begin
      rx_exp_q.push_back(w);
      tx_exp_q.push_back(shadow_model);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi_i = w[W-1-i];
      cycles(HALF);
      miso_word = {miso_word[W-2:0], miso_o};
      sclk_i = 1'b1;
      if (ack_last && i == nbits - 1) begin
        cycles(SYNC + 1);
        rx_ack = 1'b1;
        cycles(1);
        rx_ack = 1'b0;
        cycles(HALF - SYNC - 2);
      end else begin
        cycles(HALF);
      end
      sclk_i = 1'b0;
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] miso_word);
    logic [W-1:0] exp_rx, exp_tx;
    checks++;
    if (rx_exp_q.size() == 0 || tx_exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s_queue: got empty scoreboard expected entry", name);
    end else begin
      exp_rx = rx_exp_q.pop_front();
      exp_tx = tx_exp_q.pop_front();
      if (rx_data !== exp_rx) begin
        failures++;
        $display("[TB] FAIL %s_rx_data: got %h expected %h", name, rx_data, exp_rx);
      end
      checks++;
      if (miso_word !== exp_tx) begin
        failures++;
        $display("[TB] FAIL %s_miso: got %h expected %h", name, miso_word, exp_tx);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0; shadow_model = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    checks += 4;
    if (rx_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rx_data: got %h expected 0000", rx_data); end
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    if (miso_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso: got %b expected 0", miso_o); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
`ifdef SPI_SLAVE_OVERRUN_EN
    checks++;
    if (rx_overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", rx_overrun); end
`endif
  endtask

  task automatic test_basic();
    logic [W-1:0] m;
    load_tx(16'hA55A);
    cs_n_i = 1'b0;
    cycles(HALF);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    shift_word(16'h1234, W, 1'b0, m);
    cs_n_i = 1'b1;
    cycles(HALF);
    check_word("basic", m);
    checks += 2;
    if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_rx_valid: got %b expected 1", rx_valid); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
    pulse_ack();
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] m;
    load_tx(16'h0F0F);
    cs_n_i = 1'b0;
    cycles(HALF);
    shift_word(16'h00FF, W, 1'b0, m);
    check_word("b2b_first", m);
`ifdef SPI_SLAVE_OVERRUN_EN
    checks++;
    if (rx_overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_overrun: got %b expected 0", rx_overrun); end
`endif
    shift_word(16'hFF00, W, 1'b0, m);
    check_word("b2b_second", m);
    cs_n_i = 1'b1;
    cycles(HALF);
    checks++;
    if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_rx_valid: got %b expected 1", rx_valid); end
`ifdef SPI_SLAVE_OVERRUN_EN
    checks++;
    if (rx_overrun !== 1'b1) begin failures++; $display("[TB] FAIL b2b_overrun: got %b expected 1", rx_overrun); end
`endif
    pulse_ack();
`ifdef SPI_SLAVE_OVERRUN_EN
    checks++;
    if (rx_overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overrun_clear: got %b expected 0", rx_overrun); end
`endif
  endtask

  task automatic test_abort();
    logic [W-1:0] m;
    cs_n_i = 1'b0;
    cycles(HALF);
    shift_word(16'hFFFF, 7, 1'b0, m);
    cs_n_i = 1'b1;
    cycles(HALF);
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_rx_valid: got %b expected 0", rx_valid); end
    if (rx_data !== 16'hFF00) begin failures++; $display("[TB] FAIL abort_rx_data: got %h expected ff00", rx_data); end
    cs_n_i = 1'b0;
    cycles(HALF);
    shift_word(16'hBEEF, W, 1'b0, m);
    cs_n_i = 1'b1;
    cycles(HALF);
    check_word("abort_next", m);
  endtask

  task automatic test_ack_coincident();
    logic [W-1:0] m;
    load_tx(16'h3C96);
    cs_n_i = 1'b0;
    cycles(HALF);
    shift_word(16'h5A5A, W, 1'b1, m);
    cs_n_i = 1'b1;
    cycles(HALF);
    check_word("ackc", m);
    checks++;
    if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL ackc_rx_valid: got %b expected 1", rx_valid); end
`ifdef SPI_SLAVE_OVERRUN_EN
    checks++;
    if (rx_overrun !== 1'b0) begin failures++; $display("[TB] FAIL ackc_overrun: got %b expected 0", rx_overrun); end
`endif
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] m;
    load_tx(16'hC3C3);
    cs_n_i = 1'b0;
    cycles(HALF);
    shift_word(16'hFFFF, 9, 1'b0, m);
    cycles(SYNC + 2);
    checks++;
    if (miso_o !== shadow_model[W-1-9]) begin failures++; $display("[TB] FAIL midword_miso_pre: got %b expected %b", miso_o, shadow_model[W-1-9]); end
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    shadow_model = '0;
    checks += 4;
    if (rx_data !== 16'h0000) begin failures++; $display("[TB] FAIL midword_rx_data: got %h expected 0000", rx_data); end
    if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midword_rx_valid: got %b expected 0", rx_valid); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midword_busy: got %b expected 0", busy); end
    if (miso_o !== 1'b0) begin failures++; $display("[TB] FAIL midword_miso: got %b expected 0", miso_o); end
    cs_n_i = 1'b1;
    cycles(HALF);
    cs_n_i = 1'b0;
    cycles(HALF);
    shift_word(16'h1357, W, 1'b0, m);
    cs_n_i = 1'b1;
    cycles(HALF);
    check_word("recover", m);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_ack_coincident();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
